// File: rtl/stage_1_if_if.sv
// Instruction SRAM request/response bus between the fetch stage and the SRAM.
// The master drives req/addr; the slave answers with addr_ok/data_ok/rdata.
interface stage_1_if_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, addr, input addr_ok, data_ok, rdata);
  modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/stage_1_if.sv
// Pipeline stage 1 (instruction fetch): PC generation, single-outstanding SRAM fetch,
// one-entry instruction buffer toward ID, and branch redirect with wrong-path discard.
module stage_1_if #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                allow_2,
  output logic                valid_1,
  output logic [63:0]         stage_1_to_2,
  input  logic                br_taken,
  input  logic [31:0]         br_target,
  stage_1_if_if.master        inst_sram
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_tgt;
  logic        br_pend;
  logic        cancel;
  logic [63:0] inst_buf;
  logic [31:0] sel_pc;

  assign sel_pc         = br_pend ? pend_tgt : fetch_pc;
  assign inst_sram.req  = (state == REQ);
  assign inst_sram.addr = {sel_pc[31:2], 2'b00};

  // A redirect in the same cycle must block the transfer of the stale buffer.
  assign valid_1      = (state == HOLD) && !br_taken;
  assign stage_1_to_2 = inst_buf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pend_tgt <= '0;
      br_pend  <= 1'b0;
      cancel   <= 1'b0;
      inst_buf <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (inst_sram.addr_ok) begin
            fetch_pc <= inst_sram.addr;
            br_pend  <= 1'b0;
            state    <= WAIT;
            if (br_taken) cancel <= 1'b1;
          end
        end
        WAIT: begin
          if (inst_sram.data_ok) begin
            if (cancel || br_taken) begin
              cancel <= 1'b0;
              state  <= REQ;
            end else begin
              inst_buf <= {inst_sram.rdata, fetch_pc};
              state    <= HOLD;
            end
          end else if (br_taken) begin
            cancel <= 1'b1;
          end
        end
        HOLD: begin
          if (br_taken) begin
            state <= REQ;
          end else if (allow_2) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
      // Redirect capture overrides the br_pend clear on acceptance; last target wins.
      if (br_taken && state != IDLE) begin
        pend_tgt <= br_target;
        br_pend  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage_1_if.sv
// Directed bench for the fetch stage: handshake timing, stalls, redirects, reset, wrap.
module tb_stage_1_if;
  logic        clk;
  logic        resetn;
  logic        allow_2;
  logic        valid_1;
  logic [63:0] stage_1_to_2;
  logic        br_taken;
  logic [31:0] br_target;
  int          checks;
  int          failures;

  stage_1_if_if sram ();

  stage_1_if #(.RESET_PC(32'h1C00_0000)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .allow_2      (allow_2),
    .valid_1      (valid_1),
    .stage_1_to_2 (stage_1_to_2),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .inst_sram    (sram.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; allow_2 = 1'b0; br_taken = 1'b0; br_target = '0;
    sram.addr_ok = 1'b0; sram.data_ok = 1'b0; sram.rdata = '0;
    tick(); tick(); #1;
    checks++; if (sram.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", sram.req); end
    checks++; if (valid_1 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_1); end
    checks++; if (stage_1_to_2 !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", stage_1_to_2); end
  endtask

  task automatic test_basic();
    tick(); resetn = 1'b1; #1;
    checks++; if (sram.req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", sram.req); end
    tick(); sram.addr_ok = 1'b1; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h1C00_0000) begin failures++; $display("FAIL first_req got=%b/%h exp=1/1c000000", sram.req, sram.addr); end
    tick(); sram.addr_ok = 1'b0; sram.data_ok = 1'b1; sram.rdata = 32'h0280_0401; #1;
    checks++; if (sram.req !== 1'b0 || valid_1 !== 1'b0) begin failures++; $display("FAIL wait_state got req=%b valid=%b exp=0/0", sram.req, valid_1); end
    tick(); sram.data_ok = 1'b0; allow_2 = 1'b1; #1;
    checks++; if (valid_1 !== 1'b1 || stage_1_to_2 !== {32'h0280_0401, 32'h1C00_0000}) begin failures++; $display("FAIL first_out got=%b/%h exp=1/028004011c000000", valid_1, stage_1_to_2); end
    tick(); allow_2 = 1'b0; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h1C00_0004 || valid_1 !== 1'b0) begin failures++; $display("FAIL next_req got=%b/%h exp=1/1c000004", sram.req, sram.addr); end
  endtask

  task automatic test_hold_stall();
    sram.addr_ok = 1'b1;
    tick(); sram.addr_ok = 1'b0; sram.data_ok = 1'b1; sram.rdata = 32'h1111_1111;
    tick(); sram.data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (valid_1 !== 1'b1 || stage_1_to_2 !== {32'h1111_1111, 32'h1C00_0004}) begin failures++; $display("FAIL stall_%0d got=%b/%h exp=1/111111111c000004", i, valid_1, stage_1_to_2); end
      tick();
    end
    allow_2 = 1'b1; #1;
    checks++; if (valid_1 !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", valid_1); end
    tick(); allow_2 = 1'b0; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h1C00_0008) begin failures++; $display("FAIL stall_next got=%b/%h exp=1/1c000008", sram.req, sram.addr); end
  endtask

  task automatic test_br_wait();
    sram.addr_ok = 1'b1;
    tick(); sram.addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h1C00_0100;
    tick(); br_taken = 1'b0; sram.data_ok = 1'b1; sram.rdata = 32'hDEAD_BEEF; #1;
    checks++; if (valid_1 !== 1'b0) begin failures++; $display("FAIL brw_valid got=%b exp=0", valid_1); end
    tick(); sram.data_ok = 1'b0; #1;
    checks++; if (valid_1 !== 1'b0 || stage_1_to_2[63:32] !== 32'h1111_1111) begin failures++; $display("FAIL brw_drop got=%b/%h exp=0/11111111", valid_1, stage_1_to_2[63:32]); end
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h1C00_0100) begin failures++; $display("FAIL brw_redirect got=%b/%h exp=1/1c000100", sram.req, sram.addr); end
  endtask

  task automatic test_br_hold();
    sram.addr_ok = 1'b1;
    tick(); sram.addr_ok = 1'b0; sram.data_ok = 1'b1; sram.rdata = 32'h2222_2222;
    tick(); sram.data_ok = 1'b0; allow_2 = 1'b1; br_taken = 1'b1; br_target = 32'h1C00_0200; #1;
    checks++; if (valid_1 !== 1'b0) begin failures++; $display("FAIL brh_valid got=%b exp=0", valid_1); end
    tick(); br_taken = 1'b0; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h1C00_0200 || valid_1 !== 1'b0) begin failures++; $display("FAIL brh_redirect got=%b/%h exp=1/1c000200", sram.req, sram.addr); end
    allow_2 = 1'b0;
  endtask

  task automatic test_br_req_accept();
    sram.addr_ok = 1'b1; br_taken = 1'b1; br_target = 32'h1C00_0300;
    tick(); sram.addr_ok = 1'b0; br_taken = 1'b0; sram.data_ok = 1'b1; sram.rdata = 32'h3333_3333; #1;
    checks++; if (sram.req !== 1'b0) begin failures++; $display("FAIL brr_wait got=%b exp=0", sram.req); end
    tick(); sram.data_ok = 1'b0; #1;
    checks++; if (valid_1 !== 1'b0 || sram.req !== 1'b1 || sram.addr !== 32'h1C00_0300) begin failures++; $display("FAIL brr_redirect got=%b/%b/%h exp=0/1/1c000300", valid_1, sram.req, sram.addr); end
    sram.addr_ok = 1'b1;
    tick(); sram.addr_ok = 1'b0; sram.data_ok = 1'b1; sram.rdata = 32'h4444_4444;
    tick(); sram.data_ok = 1'b0; #1;
    checks++; if (valid_1 !== 1'b1 || stage_1_to_2 !== {32'h4444_4444, 32'h1C00_0300}) begin failures++; $display("FAIL brr_out got=%b/%h exp=1/444444441c000300", valid_1, stage_1_to_2); end
    allow_2 = 1'b1;
    tick(); allow_2 = 1'b0; #1;
    checks++; if (sram.addr !== 32'h1C00_0304) begin failures++; $display("FAIL brr_next got=%h exp=1c000304", sram.addr); end
  endtask

  task automatic test_reset_mid();
    sram.addr_ok = 1'b1;
    tick(); sram.addr_ok = 1'b0; #2; resetn = 1'b0; #1;
    checks++; if (sram.req !== 1'b0 || valid_1 !== 1'b0 || stage_1_to_2 !== 64'd0) begin failures++; $display("FAIL rst_mid got=%b/%b/%h exp=0/0/0", sram.req, valid_1, stage_1_to_2); end
    tick(); resetn = 1'b1; sram.data_ok = 1'b1; sram.rdata = 32'h5555_5555;
    tick(); sram.data_ok = 1'b0; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h1C00_0000 || valid_1 !== 1'b0) begin failures++; $display("FAIL rst_restart got=%b/%b/%h exp=1/0/1c000000", sram.req, valid_1, sram.addr); end
  endtask

  task automatic test_br_req_wrap();
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h1C00_0000) begin failures++; $display("FAIL wrap_pre got=%b/%h exp=1/1c000000", sram.req, sram.addr); end
    tick(); br_taken = 1'b0; sram.addr_ok = 1'b1; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_switch got=%b/%h exp=1/fffffffc", sram.req, sram.addr); end
    tick(); sram.addr_ok = 1'b0; sram.data_ok = 1'b1; sram.rdata = 32'h6666_6666;
    tick(); sram.data_ok = 1'b0; allow_2 = 1'b1; #1;
    checks++; if (valid_1 !== 1'b1 || stage_1_to_2 !== {32'h6666_6666, 32'hFFFF_FFFC}) begin failures++; $display("FAIL wrap_out got=%b/%h exp=1/66666666fffffffc", valid_1, stage_1_to_2); end
    tick(); allow_2 = 1'b0; #1;
    checks++; if (sram.req !== 1'b1 || sram.addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", sram.req, sram.addr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_hold_stall();
    test_br_wait();
    test_br_hold();
    test_br_req_accept();
    test_reset_mid();
    test_br_req_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
